// File: rtl/matrix_result_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_result_streamer_if
//  Description : Valid/ready result stream carrying data, element index, last.
//  Revision    : 1.0
// ============================================================================
interface matrix_result_streamer_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [AW-1:0] out_index;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_index,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/matrix_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_result_streamer
//  Description : Reads the 4x4 result register file and streams it out, one
//                element per beat, with last marking and singular-matrix error.
//  Revision    : 1.0
// ============================================================================
module matrix_result_streamer #(
    parameter int DW        = 32,
    parameter int AW        = 4,
    parameter int N         = 16,
    parameter int TRANSPOSE = 0
) (
    input  wire             clk,
    input  wire             rst_n,
    input  wire             start,
    input  wire             det_zero,
    output logic [AW-1:0]   rf_ra,
    input  wire  [DW-1:0]   rf_rd,
    matrix_result_streamer_if.master outs,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [AW-1:0] c_LAST = AW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [AW-1:0] r_idx;
    logic [DW-1:0] r_data;
    logic [AW-1:0] r_index;
    logic          r_last;
    logic          r_valid;
    logic          r_errPend;
    logic          w_fire;
    logic          w_atLast;

    assign w_fire   = r_valid & outs.out_ready;
    assign w_atLast = (r_idx == c_LAST);

    // Address follows idx in every state so the read data is settled by FETCH.
    generate
        if (TRANSPOSE != 0) begin : g_colMajor
            assign rf_ra = AW'({r_idx[1:0], r_idx[3:2]});
        end else begin : g_rowMajor
            assign rf_ra = r_idx;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_stateNext = det_zero ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                busy        = 1'b1;
                w_stateNext = S_SEND;
            end
            S_SEND: begin
                busy = 1'b1;
                if (w_fire) begin
                    w_stateNext = w_atLast ? S_FIN : S_FETCH;
                end
            end
            S_FIN: begin
                done        = 1'b1;
                w_stateNext = S_IDLE;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    assign err = done & r_errPend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_data    <= '0;
            r_index   <= '0;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
            r_errPend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_errPend <= det_zero;
                        if (!det_zero) begin
                            r_idx <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    r_data  <= rf_rd;
                    r_index <= r_idx;
                    r_last  <= w_atLast;
                    r_valid <= 1'b1;
                end
                S_SEND: begin
                    if (w_fire) begin
                        r_valid <= 1'b0;
                        if (w_atLast) begin
                            r_last <= 1'b0;
                        end else begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end
                S_FIN: begin
                    r_errPend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign outs.out_data  = r_data;
    assign outs.out_valid = r_valid;
    assign outs.out_last  = r_last;
    assign outs.out_index = r_index;

endmodule
`default_nettype wire

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Downstream consumer of the matrix division datapath.
- After the controller finishes writing the 4x4 result register file (R = A x B^-1), this block reads the 16 entries through a read port on that file.
- It presents them one per beat on a valid/ready output stream, with last-beat marking and an error indication when det(B) was zero.
- It owns only the result read port; it never writes any register file.

Parameters:
DW, 32, data word width (matches register file word)
AW, 4, register file address width
N, 16, number of elements streamed per frame (1..2^AW)
TRANSPOSE, 0, 0 = row-major order; 1 = column-major order (legal only with N=16)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to stream the result matrix
det_zero  input  1  det(B)==0 flag from the determinant unit, sampled when start is accepted
rf_ra  output  AW  read address to the result register file
rf_rd  input  DW  combinational read data for rf_ra
out_data  output  DW  stream data
out_valid  output  1  stream data valid
out_ready  input  1  sink ready
out_last  output  1  high with the final beat of a frame
out_index  output  AW  element index (0..N-1) of the current beat, in stream order
busy  output  1  frame in progress
done  output  1  one-cycle pulse at end of frame (normal or error)
err  output  1  one-cycle pulse, coincident with done, when a frame was refused because det_zero=1

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; idx=0. out_valid, out_last, busy, done and err are all 0. out_data=0, rf_ra=0 and out_index=0. Reset mid-frame aborts immediately: out_valid drops with no completion and done is not pulsed.
- State machine: IDLE, FETCH, SEND, FIN.
- IDLE: busy=0.
  - On start=1 with det_zero=1: next state FIN with err flagged. No beats are produced.
  - On start=1 with det_zero=0: idx<=0 and next state FETCH.
- FETCH: busy=1.
  - rf_ra = map(idx): map(i)=i when TRANSPOSE=0; map(i)={i[1:0],i[3:2]} when TRANSPOSE=1.
  - At the clock edge: out_data<=rf_rd, out_index<=idx, out_last<=(idx==N-1), out_valid<=1. Next state SEND.
- SEND: busy=1.
  - out_data, out_index and out_last hold stable while out_valid=1 and out_ready=0. Valid is never withdrawn before acceptance.
  - On out_valid&out_ready, if idx==N-1: out_valid<=0, out_last<=0, next state FIN.
  - On out_valid&out_ready otherwise: out_valid<=0, idx<=idx+1, next state FETCH.
- FIN: done=1 for exactly one cycle, and err=1 in the same cycle if the frame was refused. busy=0. Next state IDLE.
- rf_ra holds map(idx) in every state, so the address is stable through FETCH.
- Latency: the first beat is valid 2 cycles after start is accepted. Peak throughput is 1 beat per 2 cycles. An N-element frame with out_ready tied high takes 2N+1 cycles from start to the done pulse.
- start while busy=1 or in FIN is ignored, with no queuing. det_zero is only sampled in IDLE with start.
- out_ready asserted while out_valid=0 has no effect.
- idx never exceeds N-1; there is no wrap-around within a frame. A new start restarts at index 0.
- Data is not modified: no sign or width conversion; DW bits are passed through.

Test Plan:
- Row-major frame: result file holds entry k = 0x0000_0100+k, TRANSPOSE=0, out_ready=1, pulse start.
  - 16 beats: data 0x100..0x10F, out_index 0..15.
  - out_last only on 0x10F.
  - done pulse 33 cycles after start; err=0.
- Column-major frame: same file contents, TRANSPOSE=1.
  - Beat order 0x100,0x104,0x108,0x10C,0x101,...,0x10F.
  - rf_ra sequence 0,4,8,12,1,...,15.
- Backpressure: out_ready low for 5 cycles on beat 3, then toggling every cycle.
  - out_data (0x103) and out_index (3) are held stable while stalled.
  - No beat is lost or duplicated; all 16 beats arrive in order.
- Singular matrix: det_zero=1 at start.
  - out_valid never asserts.
  - done=1 and err=1 together, 1 cycle after start, for one cycle; busy=0 throughout.
- Ignored start: pulse start again during beat 7.
  - The frame completes unchanged with exactly 16 beats and one done.
  - No second frame follows.
- Reset mid-frame: assert rst_n=0 asynchronously at beat 9 with out_valid=1.
  - out_valid, busy and out_last go to 0 without waiting for a clock edge; no done.
  - After release, a new start produces a full frame from index 0.
